// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch with PC register and a single-outstanding
//            instruction-memory port. Optional FETCH_ALIGN_CHECK_EN adds a
//            misaligned-target FAULT state and the misalign_o output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_stall_i,
    input  logic [1:0]  pc_sel_i,
    input  logic        br_taken_i,
    input  logic [31:0] next_pc_i,
    output logic        memory_done_o,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    localparam logic [1:0] c_SEL_NONE   = 2'b00;
    localparam logic [1:0] c_SEL_PLUS4  = 2'b01;
    localparam logic [1:0] c_SEL_JUMP   = 2'b10;
    localparam logic [1:0] c_SEL_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        S_FAULT = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pco_q, pco_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_dest;
    logic [31:0] w_target;

    assign w_pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_dest = next_pc_i;
`else
    // Targets are word-aligned by construction when alignment is not checked.
    logic w_unused_npc;
    assign w_unused_npc = ^next_pc_i[1:0];
    assign w_dest       = {next_pc_i[31:2], 2'b00};
`endif

    always_comb begin
        w_target = pc_q;
        case (pc_sel_i)
            c_SEL_NONE:   w_target = pc_q;
            c_SEL_PLUS4:  w_target = w_pc_plus4;
            c_SEL_JUMP:   w_target = w_dest;
            c_SEL_BRANCH: w_target = br_taken_i ? w_dest : w_pc_plus4;
            default:      w_target = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pco_d   = pco_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    ir_d    = imem_rdata_i;
                    pco_d   = pc_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!fetch_stall_i) begin
                    pc_d    = w_target;
                    state_d = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (w_target[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= c_NOP;
            pco_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pco_q   <= pco_d;
        end
    end

    // All outputs are decoded from registers only.
    assign imem_req_o    = (state_q == S_REQ);
    assign memory_done_o = (state_q == S_DONE);
    assign imem_addr_o   = pc_q;
    assign ir_o          = ir_q;
    assign pc_o          = pco_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_o    = (state_q == S_FAULT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomized bench for fetch_unit with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall_i;
    logic [1:0]  pc_sel_i;
    logic        br_taken_i;
    logic [31:0] next_pc_i;
    logic        memory_done_o;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_stall_i (fetch_stall_i),
        .pc_sel_i      (pc_sel_i),
        .br_taken_i    (br_taken_i),
        .next_pc_i     (next_pc_i),
        .memory_done_o (memory_done_o),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_o    (misalign_o),
`endif
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i)
    );

    // One entry describes how the environment treats one fetch.
    typedef struct {
        int          rdy;
        int          rv;
        int          st;
        logic [1:0]  sel;
        logic        tk;
        logic [31:0] npc;
    } ent_t;

    ent_t        script[$];
    ent_t        cur;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];

    logic [31:0] m_pc, m_ir, m_pco;
    bit          m_out, m_fault, m_post, e_done, e_req, started;
    int          rdy_cnt, rv_cnt, st_cnt;
    bit          ent_loaded, rnd_rst_en, force_rst_now, force_rst_wait, spur_armed;
    int          rst_mark = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E27;
    endfunction

    function automatic logic [31:0] next_pc_of(input logic [1:0] sel, input logic tk,
                                               input logic [31:0] npc, input logic [31:0] pc);
        logic [31:0] dest;
        dest = npc;
`ifndef FETCH_ALIGN_CHECK_EN
        dest[1:0] = 2'b00;
`endif
        case (sel)
            2'd0:    return pc;
            2'd1:    return pc + 32'd4;
            2'd2:    return dest;
            default: return tk ? dest : pc + 32'd4;
        endcase
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.rdy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
        e.rv  = int'($urandom_range(1, 3));
        e.st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        e.sel = 2'($urandom_range(0, 3));
        e.tk  = 1'($urandom_range(0, 1));
        e.npc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        if ($urandom_range(0, 15) != 0) e.npc[1:0] = 2'b00;
`endif
        return e;
    endfunction

    function automatic ent_t mk(input int rdy, input int st, input logic [1:0] sel,
                                input logic tk, input logic [31:0] npc);
        ent_t e;
        e.rdy = rdy; e.rv = 1; e.st = st; e.sel = sel; e.tk = tk; e.npc = npc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: advance the model over the edge just taken, compare, drive.
    task automatic step();
        bit          was_rst, resp, decide, acc, nreq, ndone;
        logic [31:0] t;
        @(posedge clk);
        #1;
        cyc++;
        was_rst = rst;
        if (was_rst) begin
            m_pc = RESET_PC; m_ir = c_NOP; m_pco = RESET_PC;
            m_out = 0; m_fault = 0; e_done = 0; e_req = 0; m_post = 1;
            ent_loaded = 0; started = 1;
        end else if (started) begin
            resp   = imem_rvalid_i && m_out;
            decide = e_done && !fetch_stall_i;
            acc    = e_req && imem_ready_i;
            nreq   = m_post || (e_req && !imem_ready_i);
            ndone  = resp || (e_done && fetch_stall_i);
            if (resp) begin
                m_ir  = mem_word(m_pc);
                m_pco = m_pc;
                m_out = 0;
            end
            if (acc) begin
                m_out = 1;
                rv_cnt = cur.rv;
                acc_addr.push_back(m_pc);
                acc_cyc.push_back(cyc);
            end
            if (decide) begin
                t    = next_pc_of(pc_sel_i, br_taken_i, next_pc_i, m_pc);
                m_pc = t;
`ifdef FETCH_ALIGN_CHECK_EN
                if (t[1:0] != 2'b00) m_fault = 1;
                else nreq = 1;
`else
                nreq = 1;
`endif
            end
            e_req  = nreq;
            e_done = ndone;
            m_post = 0;
        end

        if (started) begin
            chk("done", {31'd0, memory_done_o}, {31'd0, e_done});
            chk("req", {31'd0, imem_req_o}, {31'd0, e_req});
            chk("addr", imem_addr_o, m_pc);
            chk("ir", ir_o, m_ir);
            chk("pc_o", pc_o, m_pco);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("misalign", {31'd0, misalign_o}, {31'd0, m_fault});
`endif
        end

        rst = 1'b0;
        if (force_rst_now) begin
            rst = 1'b1; force_rst_now = 0;
        end else if (force_rst_wait && m_out) begin
            rst = 1'b1; force_rst_wait = 0; spur_armed = 1; rst_mark = acc_addr.size();
        end else if (rnd_rst_en && $urandom_range(0, 149) == 0) begin
            rst = 1'b1;
        end

        if (e_req) begin
            if (!ent_loaded) begin
                cur = (script.size() != 0) ? script.pop_front() : rand_ent();
                rdy_cnt = cur.rdy; st_cnt = cur.st; ent_loaded = 1;
            end
            if (rdy_cnt > 0) begin
                imem_ready_i = 1'b0; rdy_cnt--;
            end else begin
                imem_ready_i = 1'b1;
            end
        end else begin
            imem_ready_i = 1'($urandom_range(0, 1));
        end

        if (spur_armed && was_rst) begin
            // Late response arriving after reset must be discarded.
            imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; spur_armed = 0;
        end else if (m_out) begin
            if (rv_cnt <= 1) begin
                imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(m_pc);
            end else begin
                imem_rvalid_i = 1'b0; imem_rdata_i = $urandom; rv_cnt--;
            end
        end else begin
            imem_rvalid_i = !(e_req && imem_ready_i) && ($urandom_range(0, 3) == 0);
            imem_rdata_i  = $urandom;
        end

        if (e_done && st_cnt == 0) begin
            fetch_stall_i = 1'b0;
            pc_sel_i = cur.sel; br_taken_i = cur.tk; next_pc_i = cur.npc;
            ent_loaded = 0;
        end else begin
            if (e_done) begin
                fetch_stall_i = 1'b1; st_cnt--;
            end else begin
                fetch_stall_i = 1'($urandom_range(0, 1));
            end
            pc_sel_i = 2'($urandom_range(0, 3)); br_taken_i = 1'($urandom_range(0, 1));
            next_pc_i = $urandom;
        end
    endtask

    initial begin
        logic [31:0] exp_a [11];
        int          n_exp;
        exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h40, 32'h40,
                  32'hFFFF_FFFC, 32'h0, 32'h100};
        rst = 1'b1; fetch_stall_i = 1'b0; pc_sel_i = 2'd0; br_taken_i = 1'b0;
        next_pc_i = 32'h0; imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        repeat (3) @(posedge clk);

        script.push_back(mk(0, 0, 2'd1, 1'b0, 32'h0));
        script.push_back(mk(0, 0, 2'd1, 1'b0, 32'h0));
        script.push_back(mk(5, 0, 2'd1, 1'b0, 32'h0));
        script.push_back(mk(0, 0, 2'd3, 1'b1, 32'h100));
        script.push_back(mk(0, 0, 2'd3, 1'b0, 32'h200));
        script.push_back(mk(0, 0, 2'd2, 1'b0, 32'h40));
        script.push_back(mk(0, 3, 2'd0, 1'b0, 32'h0));
        script.push_back(mk(0, 0, 2'd2, 1'b0, 32'hFFFF_FFFC));
        script.push_back(mk(0, 0, 2'd1, 1'b0, 32'h0));
        script.push_back(mk(0, 0, 2'd2, 1'b0, 32'h102));
        script.push_back(mk(0, 0, 2'd1, 1'b0, 32'h0));

        step();
        chk("rst_done", {31'd0, memory_done_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_ir", ir_o, c_NOP);
        chk("rst_pc", pc_o, RESET_PC);
        repeat (120) step();

`ifdef FETCH_ALIGN_CHECK_EN
        n_exp = 10;
        chk("fault_misalign", {31'd0, misalign_o}, 32'd1);
        chk("fault_addr", imem_addr_o, 32'h102);
        chk("fault_acc_count", acc_addr.size(), 32'd10);
`else
        n_exp = 11;
        chk("acc_count_ok", {31'd0, acc_addr.size() >= 11}, 32'd1);
`endif
        for (int i = 0; i < n_exp; i++) begin
            chk($sformatf("acc_addr[%0d]", i), (i < acc_addr.size()) ? acc_addr[i] : 32'hXXXX_XXXX,
                exp_a[i]);
        end
        if (acc_cyc.size() >= 8) begin
            chk("period_zero_wait", acc_cyc[1] - acc_cyc[0], 32'd3);
            chk("period_ready_stall", acc_cyc[2] - acc_cyc[1], 32'd8);
            chk("period_fetch_stall", acc_cyc[7] - acc_cyc[6], 32'd6);
        end else begin
            chk("acc_cyc_count", acc_cyc.size(), 32'd8);
        end

        force_rst_now = 1;
        step();
        force_rst_wait = 1;
        repeat (25) step();
        chk("rst_in_wait_seen", {31'd0, rst_mark >= 0}, 32'd1);
        chk("restart_addr", (rst_mark >= 0 && acc_addr.size() > rst_mark) ? acc_addr[rst_mark]
                                                                       : 32'hXXXX_XXXX, RESET_PC);

        rnd_rst_en = 1;
        repeat (4000) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
